// File: rtl/light_sequencer.sv
// Traffic light sequencer: main/side road cycle with pedestrian phase and
// flashing night operation, paced by an external seconds timer.
module light_sequencer #(
    parameter int unsigned T_MAIN_GREEN = 30,
    parameter int unsigned T_SIDE_GREEN = 20,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 2,
    parameter int unsigned T_PED        = 10,
    parameter int unsigned T_FLASH      = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        finished,
    input  logic        ped_req,
    input  logic        night_mode,
    output logic        timer_en,
    output logic        timer_clr,
    output logic [15:0] seconds_to_count,
    output logic [2:0]  main_light,
    output logic [2:0]  side_light,
    output logic        ped_walk,
    output logic [2:0]  state_code
);

    localparam int unsigned SEC_W = 16;

    localparam logic [2:0] S_MG    = 3'd0;
    localparam logic [2:0] S_MY    = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_SG    = 3'd3;
    localparam logic [2:0] S_SY    = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_PED   = 3'd6;
    localparam logic [2:0] S_FLASH = 3'd7;

    localparam logic [1:0] PH_ARM    = 2'd0;
    localparam logic [1:0] PH_GUARD1 = 2'd1;
    localparam logic [1:0] PH_GUARD2 = 2'd2;
    localparam logic [1:0] PH_RUN    = 2'd3;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;

    logic [2:0]       state, state_nx;
    logic [1:0]       phase, phase_nx;
    logic             started, started_nx;
    logic             pending, pending_nx;
    logic             blink, blink_nx;
    logic             done;
    logic             timer_en_nx, timer_clr_nx, ped_walk_nx;
    logic [SEC_W-1:0] secs_nx;
    logic [2:0]       main_nx, side_nx;

    assign state_code = state;

    // State, phase and registered outputs; reset parks in AR2 ARM with the timer idle
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state            <= S_AR2;
            phase            <= PH_ARM;
            started          <= 1'b0;
            pending          <= 1'b0;
            blink            <= 1'b1;
            timer_en         <= 1'b0;
            timer_clr        <= 1'b0;
            seconds_to_count <= SEC_W'(T_ALL_RED);
            main_light       <= LAMP_R;
            side_light       <= LAMP_R;
            ped_walk         <= 1'b0;
        end else begin
            state            <= state_nx;
            phase            <= phase_nx;
            started          <= started_nx;
            pending          <= pending_nx;
            blink            <= blink_nx;
            timer_en         <= timer_en_nx;
            timer_clr        <= timer_clr_nx;
            seconds_to_count <= secs_nx;
            main_light       <= main_nx;
            side_light       <= side_nx;
            ped_walk         <= ped_walk_nx;
        end
    end

    // Next state/phase, pedestrian latch, blink, and the lamp/duration decode of the next state
    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        started_nx  = 1'b1;
        pending_nx  = pending;
        blink_nx    = blink;
        done        = 1'b0;
        main_nx     = LAMP_R;
        side_nx     = LAMP_R;
        ped_walk_nx = 1'b0;
        secs_nx     = SEC_W'(T_ALL_RED);
        timer_en_nx = 1'b1;

        // First edge after reset only launches the ARM cycle of the reset state
        if (!started) begin
            phase_nx = PH_ARM;
        end else begin
            case (phase)
                PH_ARM:    phase_nx = PH_GUARD1;
                PH_GUARD1: phase_nx = PH_GUARD2;
                PH_GUARD2: phase_nx = PH_RUN;
                default: begin
                    if (finished) begin
                        done     = 1'b1;
                        phase_nx = PH_ARM;
                    end
                end
            endcase
        end

        if (done) begin
            case (state)
                S_MG:  state_nx = S_MY;
                S_MY:  state_nx = S_AR1;
                S_AR1: state_nx = night_mode ? S_FLASH : S_SG;
                S_SG:  state_nx = S_SY;
                S_SY:  state_nx = S_AR2;
                S_AR2: begin
                    if (night_mode)
                        state_nx = S_FLASH;
                    else if (pending || ped_req)
                        state_nx = S_PED;
                    else
                        state_nx = S_MG;
                end
                S_PED: state_nx = S_MG;
                default: state_nx = night_mode ? S_FLASH : S_AR2;
            endcase
        end

        // Blink restarts lit on FLASH entry and toggles on each FLASH-to-FLASH pass
        if (done && state_nx == S_FLASH)
            blink_nx = (state == S_FLASH) ? ~blink : 1'b1;

        // Request is consumed by PED entry; a request seen while in PED is dropped
        if (done && state_nx == S_PED)
            pending_nx = 1'b0;
        else if (ped_req && state != S_PED)
            pending_nx = 1'b1;

        timer_clr_nx = (phase_nx == PH_ARM);

        case (state_nx)
            S_MG: begin
                main_nx = LAMP_G;
                secs_nx = SEC_W'(T_MAIN_GREEN);
            end
            S_MY: begin
                main_nx = LAMP_Y;
                secs_nx = SEC_W'(T_YELLOW);
            end
            S_SG: begin
                side_nx = LAMP_G;
                secs_nx = SEC_W'(T_SIDE_GREEN);
            end
            S_SY: begin
                side_nx = LAMP_Y;
                secs_nx = SEC_W'(T_YELLOW);
            end
            S_PED: begin
                ped_walk_nx = 1'b1;
                secs_nx     = SEC_W'(T_PED);
            end
            S_FLASH: begin
                main_nx = blink_nx ? LAMP_Y : LAMP_OFF;
                side_nx = blink_nx ? LAMP_R : LAMP_OFF;
                secs_nx = SEC_W'(T_FLASH);
            end
            default: begin
                secs_nx = SEC_W'(T_ALL_RED);
            end
        endcase
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: a transaction-level model predicts each
// state's outputs and length; a negedge monitor compares when timer_clr marks a new state.
module tb_light_sequencer;

    localparam int unsigned T_MG  = 30;
    localparam int unsigned T_SG  = 20;
    localparam int unsigned T_Y   = 3;
    localparam int unsigned T_AR  = 2;
    localparam int unsigned T_PD  = 10;
    localparam int unsigned T_FL  = 1;

    typedef enum int {M_MG, M_MY, M_AR1, M_SG, M_SY, M_AR2, M_PED, M_FLASH} mst_t;

    typedef struct {
        logic [2:0]  code;
        logic [2:0]  ml;
        logic [2:0]  sl;
        logic        walk;
        logic [15:0] secs;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        finished;
    logic        ped_req;
    logic        night_mode;
    logic        timer_en;
    logic        timer_clr;
    logic [15:0] seconds_to_count;
    logic [2:0]  main_light;
    logic [2:0]  side_light;
    logic        ped_walk;
    logic [2:0]  state_code;

    exp_t exp_q[$];
    int   len_q[$];
    int   total = 0;
    int   bad = 0;
    int   tcnt = 0;
    int   fin_mode = 0;     // 0: seconds timer model, 1: always finished, 2: random
    int   states_seen = 0;

    light_sequencer dut (
        .CLK(CLK),
        .reset(reset),
        .finished(finished),
        .ped_req(ped_req),
        .night_mode(night_mode),
        .timer_en(timer_en),
        .timer_clr(timer_clr),
        .seconds_to_count(seconds_to_count),
        .main_light(main_light),
        .side_light(side_light),
        .ped_walk(ped_walk),
        .state_code(state_code)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Expected outputs of a state, straight from the state table
    function automatic exp_t expect_for(input mst_t s, input bit blk);
        exp_t e;
        e.ml = 3'b100; e.sl = 3'b100; e.walk = 1'b0; e.secs = 16'(T_AR); e.code = 3'd5;
        case (s)
            M_MG:  begin e.code = 3'd0; e.ml = 3'b001; e.secs = 16'(T_MG); end
            M_MY:  begin e.code = 3'd1; e.ml = 3'b010; e.secs = 16'(T_Y); end
            M_AR1: begin e.code = 3'd2; e.secs = 16'(T_AR); end
            M_SG:  begin e.code = 3'd3; e.sl = 3'b001; e.secs = 16'(T_SG); end
            M_SY:  begin e.code = 3'd4; e.sl = 3'b010; e.secs = 16'(T_Y); end
            M_AR2: begin e.code = 3'd5; e.secs = 16'(T_AR); end
            M_PED: begin e.code = 3'd6; e.walk = 1'b1; e.secs = 16'(T_PD); end
            default: begin
                e.code = 3'd7;
                e.ml = blk ? 3'b010 : 3'b000;
                e.sl = blk ? 3'b100 : 3'b000;
                e.secs = 16'(T_FL);
            end
        endcase
        return e;
    endfunction

    function automatic mst_t next_of(input mst_t s, input bit night, input bit ped);
        case (s)
            M_MG:  return M_MY;
            M_MY:  return M_AR1;
            M_AR1: return night ? M_FLASH : M_SG;
            M_SG:  return M_SY;
            M_SY:  return M_AR2;
            M_AR2: return night ? M_FLASH : (ped ? M_PED : M_MG);
            M_PED: return M_MG;
            default: return night ? M_FLASH : M_AR2;
        endcase
    endfunction

    // Seconds timer stand-in: one "second" per enabled clock
    always @(posedge CLK) begin
        if (timer_clr) tcnt <= 0;
        else if (timer_en) tcnt <= tcnt + 1;
    end

    // finished driver
    initial begin
        finished = 1'b0;
        forever begin
            @(negedge CLK);
            case (fin_mode)
                0: finished = (tcnt >= int'(seconds_to_count));
                1: finished = 1'b1;
                default: finished = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    // Reference model: a state ends at the first cycle from its 4th on where finished is seen
    initial begin
        bit   m_started, m_pending, m_blink, f, p, n;
        mst_t m_st, nx;
        int   m_k;
        m_started = 0; m_pending = 0; m_blink = 1; m_st = M_AR2; m_k = 0;
        forever begin
            @(posedge CLK);
            f = finished; p = ped_req; n = night_mode;
            if (reset) begin
                m_started = 0; m_pending = 0; m_blink = 1; m_st = M_AR2;
            end else if (!m_started) begin
                m_started = 1; m_k = 0;
                exp_q.push_back(expect_for(m_st, m_blink));
            end else if (m_k >= 3 && f) begin
                nx = next_of(m_st, n, m_pending || p);
                len_q.push_back(m_k + 1);
                if (nx == M_PED) m_pending = 0;
                else if (p && m_st != M_PED) m_pending = 1;
                if (nx == M_FLASH) m_blink = (m_st == M_FLASH) ? !m_blink : 1'b1;
                m_st = nx; m_k = 0;
                exp_q.push_back(expect_for(m_st, m_blink));
            end else begin
                if (p && m_st != M_PED) m_pending = 1;
                m_k++;
            end
        end
    end

    // Monitor: a timer_clr cycle presents a new state
    initial begin
        bit          have_prev;
        int          cyc;
        logic [15:0] cur_secs;
        exp_t        e;
        have_prev = 0; cyc = 0; cur_secs = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                have_prev = 0;
            end else if (timer_clr) begin
                if (have_prev) begin
                    if (len_q.size() == 0) chk("state_len_missing", 32'(cyc), 0);
                    else chk("state_len", 32'(cyc), 32'(len_q.pop_front()));
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_state", 32'(state_code), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("state_code", 32'(state_code), 32'(e.code));
                    chk("main_light", 32'(main_light), 32'(e.ml));
                    chk("side_light", 32'(side_light), 32'(e.sl));
                    chk("ped_walk", 32'(ped_walk), 32'(e.walk));
                    chk("seconds", 32'(seconds_to_count), 32'(e.secs));
                end
                chk("clr_with_en", 32'(timer_en), 1);
                have_prev = 1; cyc = 1; cur_secs = seconds_to_count; states_seen++;
            end else if (have_prev) begin
                cyc++;
                chk("en_held", 32'(timer_en), 1);
                chk("secs_stable", 32'(seconds_to_count), 32'(cur_secs));
                chk("lamp_conflict", 32'((main_light[1:0] != 2'b00) && (side_light[1:0] != 2'b00)), 0);
            end
        end
    end

    task automatic wait_code(input logic [2:0] c, input int budget, input string nm, output bit ok);
        int k;
        ok = 0; k = 0;
        while (!ok && k < budget) begin
            @(negedge CLK);
            if (timer_clr === 1'b1 && state_code === c) ok = 1;
            k++;
        end
        if (!ok) chk({"timeout_", nm}, 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_code"}, 32'(state_code), 5);
        chk({tag, "_main"}, 32'(main_light), 32'b100);
        chk({tag, "_side"}, 32'(side_light), 32'b100);
        chk({tag, "_walk"}, 32'(ped_walk), 0);
        chk({tag, "_en"}, 32'(timer_en), 0);
        chk({tag, "_clr"}, 32'(timer_clr), 0);
        chk({tag, "_secs"}, 32'(seconds_to_count), 32'(T_AR));
    endtask

    initial begin
        bit ok;
        reset = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("rst");
        #1 reset = 1'b0;

        // Nominal cycle with the timer model
        repeat (140) @(negedge CLK);

        // Pedestrian pulse during SG
        wait_code(3'd3, 300, "sg_for_ped", ok);
        @(negedge CLK); ped_req = 1'b1;
        @(negedge CLK); ped_req = 1'b0;
        wait_code(3'd6, 100, "ped_entry", ok);
        if (ok) chk("ped_walk_on", 32'(ped_walk), 1);
        repeat (120) @(negedge CLK);

        // Night flashing
        wait_code(3'd1, 300, "my_for_night", ok);
        night_mode = 1'b1;
        wait_code(3'd7, 100, "flash_entry", ok);
        repeat (30) @(negedge CLK);
        night_mode = 1'b0;
        repeat (80) @(negedge CLK);

        // Continuous finished: every state is minimum length
        fin_mode = 1;
        repeat (60) @(negedge CLK);
        wait_code(3'd5, 100, "ar2_force", ok);
        repeat (3) @(negedge CLK);
        ped_req = 1'b1;
        @(negedge CLK); ped_req = 1'b0;
        if (timer_clr === 1'b1) chk("ar2_same_cycle_ped", 32'(state_code), 6);
        else chk("ar2_same_cycle_ped_clr", 32'(timer_clr), 1);
        repeat (40) @(negedge CLK);

        // Random finished, pedestrian and night traffic
        fin_mode = 2;
        repeat (1500) begin
            @(negedge CLK);
            ped_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) night_mode = ~night_mode;
        end
        ped_req = 1'b0; night_mode = 1'b0; fin_mode = 0;
        repeat (100) @(negedge CLK);

        // Reset pulse in SG RUN
        wait_code(3'd3, 400, "sg_for_reset", ok);
        repeat (6) @(negedge CLK);
        @(posedge CLK); #2;
        reset = 1'b1;
        exp_q.delete(); len_q.delete();
        #1 check_reset_values("async_rst");
        @(posedge CLK); #2;
        reset = 1'b0;
        wait_code(3'd5, 4, "restart_ar2", ok);
        repeat (150) @(negedge CLK);

        chk("states_seen_min", 32'(states_seen >= 60), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
